// File: rtl/fpu_cpx_rcv.sv
// fpu_cpx_rcv: receive endpoint for FPU result packets on the 145-bit CPX
// return bus. Registers each packet, checks its fixed fields, and buffers the
// decoded result in a first-word-fall-through FIFO for the core-side FP unit.
// Latency: packet at cycle N is visible at out_vld in cycle N+2 (empty FIFO).
// Backpressure: none toward the FPU; a packet that finds the FIFO full (with
// no pop that cycle) is dropped and sets sticky ovf_err. A malformed valid
// packet is dropped and sets sticky fmt_err. err_clr clears both; a set
// event in the same cycle wins.
// Ports: rclk/rst (async, active-high); cpx_fp_data in; out_vld/out_rdy plus
// decoded out_* fields toward the consumer; fifo_cnt occupancy; error flags.
// Optional: define FPU_CPX_RCV_AEXC_EN for per-thread accrued exceptions
// (aexc, cleared per thread by aexc_clr). Without it aexc is tied to 0.

module fpu_cpx_rcv #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic [144:0]  cpx_fp_data,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [1:0]    out_tid,
    output logic [4:0]    out_exc,
    output logic          out_fcmp,
    output logic [1:0]    out_cc,
    output logic [1:0]    out_fcc,
    output logic [63:0]   out_data,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf_err,
    output logic          fmt_err,
    input  logic          err_clr,
    input  logic [3:0]    aexc_clr,
    output logic [19:0]   aexc
);

    typedef struct packed {
        logic [1:0]  tid;
        logic [4:0]  exc;
        logic        fcmp;
        logic [1:0]  cc;
        logic [1:0]  fcc;
        logic [63:0] data;
    } entry_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Stage 1: plain register of the incoming packet.
    logic         s1_vld;
    logic [143:0] s1_pkt;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_pkt <= '0;
        end else begin
            s1_vld <= cpx_fp_data[144];
            s1_pkt <= cpx_fp_data[143:0];
        end
    end

    // Every field outside the result payload must hold its fixed value.
    logic fields_ok;
    logic well_formed;
    assign fields_ok = (s1_pkt[143:140] == 4'b1000) &&
                       (s1_pkt[139:136] == 4'b0000) &&
                       (s1_pkt[133:77]  == '0)      &&
                       (s1_pkt[71:70]   == 2'b00)   &&
                       !s1_pkt[64];
    assign well_formed = s1_vld && fields_ok;

    entry_t wr_entry;
    assign wr_entry = '{tid:  s1_pkt[135:134],
                        exc:  s1_pkt[76:72],
                        fcmp: s1_pkt[69],
                        cc:   s1_pkt[68:67],
                        fcc:  s1_pkt[66:65],
                        data: s1_pkt[63:0]};

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          fmt_set;

    assign full    = (fifo_cnt == FULL_CNT);
    assign out_vld = (fifo_cnt != '0);
    assign pop     = out_vld && out_rdy;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    assign push    = well_formed && (!full || pop);
    assign ovf_set = well_formed && full && !pop;
    assign fmt_set = s1_vld && !fields_ok;

    // Storage is reset so the head fields read as zero out of reset.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_err  <= 1'b0;
            fmt_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            ovf_err <= ovf_set || (ovf_err && !err_clr);
            fmt_err <= fmt_set || (fmt_err && !err_clr);
        end
    end

    // First-word-fall-through: outputs come straight off the head entry.
    entry_t head;
    assign head     = mem[rd_ptr];
    assign out_tid  = head.tid;
    assign out_exc  = head.exc;
    assign out_fcmp = head.fcmp;
    assign out_cc   = head.cc;
    assign out_fcc  = head.fcc;
    assign out_data = head.data;

`ifdef FPU_CPX_RCV_AEXC_EN
    // Clear applies first, so a write in the same cycle leaves just its exc.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            aexc <= '0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                if (push && (wr_entry.tid == 2'(t))) begin
                    aexc[5*t +: 5] <= (aexc_clr[t] ? 5'd0 : aexc[5*t +: 5]) | wr_entry.exc;
                end else if (aexc_clr[t]) begin
                    aexc[5*t +: 5] <= 5'd0;
                end
            end
        end
    end
`else
    logic unused_aexc_clr;
    assign unused_aexc_clr = ^aexc_clr;
    assign aexc = '0;
`endif

endmodule

// File: tb/tb_fpu_cpx_rcv.sv
// Bench for fpu_cpx_rcv: a table of directed cycles with constant expected
// outputs, hand-written reset and accrued-exception sequences, and a random
// phase checked every cycle against a queue-based reference model.

module tb_fpu_cpx_rcv;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          rclk = 1'b0;
    logic          rst;
    logic [144:0]  cpx_fp_data;
    logic          out_rdy;
    logic          out_vld;
    logic [1:0]    out_tid;
    logic [4:0]    out_exc;
    logic          out_fcmp;
    logic [1:0]    out_cc;
    logic [1:0]    out_fcc;
    logic [63:0]   out_data;
    logic [AW:0]   fifo_cnt;
    logic          ovf_err;
    logic          fmt_err;
    logic          err_clr;
    logic [3:0]    aexc_clr;
    logic [19:0]   aexc;

    always #5 rclk = ~rclk;

    fpu_cpx_rcv #(.DEPTH(DEPTH), .AW(AW)) dut (
        .rclk(rclk), .rst(rst), .cpx_fp_data(cpx_fp_data), .out_rdy(out_rdy),
        .out_vld(out_vld), .out_tid(out_tid), .out_exc(out_exc),
        .out_fcmp(out_fcmp), .out_cc(out_cc), .out_fcc(out_fcc),
        .out_data(out_data), .fifo_cnt(fifo_cnt), .ovf_err(ovf_err),
        .fmt_err(fmt_err), .err_clr(err_clr), .aexc_clr(aexc_clr), .aexc(aexc)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  tid;
        logic [4:0]  exc;
        logic        fcmp;
        logic [1:0]  cc;
        logic [1:0]  fcc;
        logic [63:0] data;
    } ent_t;

    ent_t         mq[$];
    logic [144:0] m_pend;
    bit           m_ovf;
    bit           m_fmt;
    logic [4:0]   m_aexc[4];

    function automatic bit wellformed(input logic [144:0] p);
        return p[144] && p[143:140] == 4'd8 && p[139:136] == 4'd0 &&
               p[133:77] == '0 && p[71:70] == 2'd0 && p[64] == 1'b0;
    endfunction

    function automatic logic [75:0] hd_of(input logic [144:0] p);
        return {p[135:134], p[76:72], p[69], p[68:67], p[66:65], p[63:0]};
    endfunction

    function automatic logic [144:0] mk(input logic [1:0] tid, input logic [4:0] exc,
                                        input logic fcmp, input logic [1:0] cc,
                                        input logic [1:0] fcc, input logic [63:0] data);
        logic [144:0] p;
        p = '0;
        p[144] = 1'b1;
        p[143:140] = 4'b1000;
        p[135:134] = tid;
        p[76:72] = exc;
        p[69] = fcmp;
        p[68:67] = cc;
        p[66:65] = fcc;
        p[63:0] = data;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = '0;
        m_ovf = 0;
        m_fmt = 0;
        for (int t = 0; t < 4; t++) m_aexc[t] = '0;
    endtask

    // Drive one cycle's inputs, advance the model across the edge, then let
    // the DUT take the edge and settle.
    task automatic cycle(input logic [144:0] pkt, input bit rdy, input bit clr, input logic [3:0] aclr);
        bit   pop, push, ovf_set, fmt_set;
        ent_t e;
        cpx_fp_data = pkt;
        out_rdy     = rdy;
        err_clr     = clr;
        aexc_clr    = aclr;
        pop = (mq.size() != 0) && rdy;
        push = 0; ovf_set = 0; fmt_set = 0;
        if (m_pend[144]) begin
            if (!wellformed(m_pend))                 fmt_set = 1;
            else if (mq.size() == DEPTH && !pop)     ovf_set = 1;
            else                                      push = 1;
        end
        e = ent_t'(hd_of(m_pend));
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(e);
        for (int t = 0; t < 4; t++) begin
            if (aclr[t]) m_aexc[t] = '0;
            if (push && e.tid == 2'(t)) m_aexc[t] = m_aexc[t] | e.exc;
        end
        m_ovf = ovf_set || (m_ovf && !clr);
        m_fmt = fmt_set || (m_fmt && !clr);
        m_pend = pkt;
        @(posedge rclk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".vld"}, 80'(out_vld), 80'(mq.size() != 0));
        check({tag, ".cnt"}, 80'(fifo_cnt), 80'(mq.size()));
        if (mq.size() != 0)
            check({tag, ".head"}, 80'({out_tid, out_exc, out_fcmp, out_cc, out_fcc, out_data}), 80'(mq[0]));
        check({tag, ".ovf"}, 80'(ovf_err), 80'(m_ovf));
        check({tag, ".fmt"}, 80'(fmt_err), 80'(m_fmt));
`ifdef FPU_CPX_RCV_AEXC_EN
        check({tag, ".aexc"}, 80'(aexc), 80'({m_aexc[3], m_aexc[2], m_aexc[1], m_aexc[0]}));
`else
        check({tag, ".aexc"}, 80'(aexc), 80'(0));
`endif
    endtask

    task automatic do_reset(input string tag);
        cpx_fp_data = '0; out_rdy = 0; err_clr = 0; aexc_clr = '0;
        rst = 1'b1;
        #3;
        check({tag, ".rst_vld"}, 80'(out_vld), 80'(0));
        check({tag, ".rst_cnt"}, 80'(fifo_cnt), 80'(0));
        check({tag, ".rst_err"}, 80'({ovf_err, fmt_err}), 80'(0));
        check({tag, ".rst_head"}, 80'({out_tid, out_exc, out_fcmp, out_cc, out_fcc, out_data}), 80'(0));
        check({tag, ".rst_aexc"}, 80'(aexc), 80'(0));
        @(posedge rclk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [144:0] pkt;
        bit           rdy;
        bit           clr;
        bit           vld;
        int           cnt;
        bit           ovf;
        bit           fmt;
        bit           chk_hd;
        logic [75:0]  hd;
    } vec_t;

    function automatic vec_t v(input logic [144:0] pkt, input bit rdy, input bit clr,
                               input bit vld, input int cnt, input bit ovf, input bit fmt,
                               input bit chk_hd, input logic [75:0] hd);
        vec_t r;
        r.pkt = pkt; r.rdy = rdy; r.clr = clr; r.vld = vld; r.cnt = cnt;
        r.ovf = ovf; r.fmt = fmt; r.chk_hd = chk_hd; r.hd = hd;
        return r;
    endfunction

    vec_t         tbl[27];
    logic [144:0] p1, p2, bad1, bad2, garb, z;
    logic [144:0] d[7];
    logic [75:0]  h1, h2;

    initial begin
        rst = 1'b0;
        cpx_fp_data = '0; out_rdy = 0; err_clr = 0; aexc_clr = '0;
        model_reset();
        #1;
        do_reset("init");

        z    = '0;
        p1   = mk(2'd2, 5'h01, 1'b0, 2'd0, 2'd0, 64'h3FF0_0000_0000_0000);
        p2   = mk(2'd0, 5'h00, 1'b1, 2'b10, 2'b01, 64'h0000_0000_0000_0002);
        for (int k = 1; k <= 6; k++)
            d[k] = mk(2'(k), 5'(k), 1'b0, 2'd0, 2'd0, 64'hDA7A_0000_0000_0000 + 64'(k));
        bad1 = p1; bad1[143:140] = 4'b0100;
        bad2 = p1; bad2[133] = 1'b1;
        garb = {1'b0, {36{4'hF}}};
        h1 = 76'({2'd2, 5'h01, 1'b0, 2'd0, 2'd0, 64'h3FF0_0000_0000_0000});
        h2 = 76'({2'd0, 5'h00, 1'b1, 2'd2, 2'd1, 64'h2});

        //           pkt   rdy clr vld cnt ovf fmt chk hd
        tbl[0]  = v(p1,   0, 0, 0, 0, 0, 0, 0, '0);
        tbl[1]  = v(z,    0, 0, 1, 1, 0, 0, 1, h1);
        tbl[2]  = v(z,    1, 0, 0, 0, 0, 0, 0, '0);
        tbl[3]  = v(p2,   1, 0, 0, 0, 0, 0, 0, '0);
        tbl[4]  = v(z,    1, 0, 1, 1, 0, 0, 1, h2);
        tbl[5]  = v(z,    1, 0, 0, 0, 0, 0, 0, '0);
        tbl[6]  = v(d[1], 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[7]  = v(d[2], 0, 0, 1, 1, 0, 0, 1, hd_of(d[1]));
        tbl[8]  = v(d[3], 0, 0, 1, 2, 0, 0, 1, hd_of(d[1]));
        tbl[9]  = v(d[4], 0, 0, 1, 3, 0, 0, 1, hd_of(d[1]));
        tbl[10] = v(d[5], 0, 0, 1, 4, 0, 0, 1, hd_of(d[1]));
        tbl[11] = v(z,    0, 0, 1, 4, 1, 0, 1, hd_of(d[1]));
        tbl[12] = v(z,    0, 1, 1, 4, 0, 0, 1, hd_of(d[1]));
        tbl[13] = v(d[6], 0, 0, 1, 4, 0, 0, 1, hd_of(d[1]));
        tbl[14] = v(z,    1, 0, 1, 4, 0, 0, 1, hd_of(d[2]));
        tbl[15] = v(z,    1, 0, 1, 3, 0, 0, 1, hd_of(d[3]));
        tbl[16] = v(z,    1, 0, 1, 2, 0, 0, 1, hd_of(d[4]));
        tbl[17] = v(z,    1, 0, 1, 1, 0, 0, 1, hd_of(d[6]));
        tbl[18] = v(z,    1, 0, 0, 0, 0, 0, 0, '0);
        tbl[19] = v(bad1, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[20] = v(bad2, 0, 0, 0, 0, 0, 1, 0, '0);
        tbl[21] = v(z,    0, 0, 0, 0, 0, 1, 0, '0);
        tbl[22] = v(z,    0, 1, 0, 0, 0, 0, 0, '0);
        tbl[23] = v(garb, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[24] = v(z,    0, 0, 0, 0, 0, 0, 0, '0);
        tbl[25] = v(bad1, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[26] = v(z,    0, 1, 0, 0, 0, 1, 0, '0);

        for (int i = 0; i < 27; i++) begin
            cycle(tbl[i].pkt, tbl[i].rdy, tbl[i].clr, 4'd0);
            check($sformatf("row%0d.vld", i), 80'(out_vld), 80'(tbl[i].vld));
            check($sformatf("row%0d.cnt", i), 80'(fifo_cnt), 80'(tbl[i].cnt));
            check($sformatf("row%0d.ovf", i), 80'(ovf_err), 80'(tbl[i].ovf));
            check($sformatf("row%0d.fmt", i), 80'(fmt_err), 80'(tbl[i].fmt));
            if (tbl[i].chk_hd)
                check($sformatf("row%0d.head", i),
                      80'({out_tid, out_exc, out_fcmp, out_cc, out_fcc, out_data}), 80'(tbl[i].hd));
        end

        // Reset in the middle of operation throws away buffered entries.
        cycle(d[1], 0, 0, 4'd0);
        cycle(d[2], 0, 0, 4'd0);
        cycle(z,    0, 0, 4'd0);
        check("midrst.pre_cnt", 80'(fifo_cnt), 80'(2));
        do_reset("midrst");

        // Accrued exceptions per thread.
        cycle(mk(2'd1, 5'h02, 0, 0, 0, 64'h11), 1, 0, 4'd0); check_model("ax0");
        cycle(mk(2'd1, 5'h10, 0, 0, 0, 64'h12), 1, 0, 4'd0); check_model("ax1");
        cycle(mk(2'd0, 5'h04, 0, 0, 0, 64'h13), 1, 0, 4'd0); check_model("ax2");
        cycle(z, 1, 0, 4'd0);                                check_model("ax3");
        cycle(z, 1, 0, 4'd0);                                check_model("ax4");
`ifdef FPU_CPX_RCV_AEXC_EN
        check("aexc.t1_acc", 80'(aexc[9:5]), 80'(5'h12));
        check("aexc.t0_acc", 80'(aexc[4:0]), 80'(5'h04));
        check("aexc.t23", 80'(aexc[19:10]), 80'(0));
        cycle(z, 1, 0, 4'b0010);
        check("aexc.t1_clr", 80'(aexc[9:5]), 80'(0));
        check("aexc.t0_keep", 80'(aexc[4:0]), 80'(5'h04));
        cycle(mk(2'd1, 5'h01, 0, 0, 0, 64'h14), 1, 0, 4'd0);
        cycle(z, 1, 0, 4'b0010);
        check("aexc.clr_and_write", 80'(aexc[9:5]), 80'(5'h01));
`else
        check("aexc.tied_off", 80'(aexc), 80'(0));
`endif

        // Random traffic against the model; low out_rdy first to reach full.
        do_reset("rand");
        for (int n = 0; n < 600; n++) begin
            logic [144:0] p;
            int           r;
            bit           rdy;
            r = $urandom_range(0, 9);
            p = mk(2'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                   {$urandom, $urandom});
            if (r == 6) begin
                case ($urandom_range(0, 4))
                    0: p[143:140] = 4'($urandom_range(0, 7));
                    1: p[139:136] = 4'($urandom_range(1, 15));
                    2: p[77 + $urandom_range(0, 56)] = 1'b1;
                    3: p[70 + $urandom_range(0, 1)] = 1'b1;
                    default: p[64] = 1'b1;
                endcase
            end else if (r == 7) begin
                p = {1'b0, $urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            end else if (r >= 8) begin
                p = '0;
            end
            rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(p, rdy, $urandom_range(0, 25) == 0,
                  ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_cpx_rcv.md
Name: fpu_cpx_rcv

Overview:
- Receive-side endpoint for FPU result packets on the 145-bit CPX return bus: registers, validates and decodes each packet, then buffers it in a FIFO for the core-side FP unit.
- Handshake toward the consumer is ready/valid.
- The FPU cannot be stalled, so this block sets a sticky error flag on overflow or on a malformed packet.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16)
- AW, 2, pointer width = log2(DEPTH)

Ports:
- rclk  input  1  global clock, rising edge
- rst  input  1  asynchronous active-high reset
- cpx_fp_data  input  145  CPX packet from FPU; bit144 valid
- out_rdy  input  1  consumer accepts head entry
- out_vld  output  1  head entry valid
- out_tid  output  2  thread ID (pkt[135:134])
- out_exc  output  5  exception flags (pkt[76:72])
- out_fcmp  output  1  compare-op result flag (pkt[69])
- out_cc  output  2  compare condition (pkt[68:67])
- out_fcc  output  2  fcc passthrough (pkt[66:65])
- out_data  output  64  result data (pkt[63:0])
- fifo_cnt  output  AW+1  occupied entries
- ovf_err  output  1  sticky: valid packet dropped while full
- fmt_err  output  1  sticky: malformed packet dropped
- err_clr  input  1  synchronous clear of ovf_err, fmt_err
- aexc_clr  input  4  per-thread accrued-exception clear (optional feature only)
- aexc  output  20  per-thread accrued exceptions, thread t at [5t+4:5t] (optional feature only)

Behaviour:
- Reset:
  - Asynchronous reset and active-high, as already decided. Clock port is rclk; reset port is rst.
  - While rst is high: out_vld=0, fifo_cnt=0, pointers=0, ovf_err=0, fmt_err=0, aexc=0, stage-1 valid=0.
  - out_tid, out_exc, out_fcmp, out_cc, out_fcc, out_data reset to 0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Stage 1 (cycle N+1):
  - Registers cpx_fp_data presented at cycle N. Stage-1 valid = bit144.
- Stage 1 decode:
  - Well-formed = valid & [143:140]==4'b1000 & [139:136]==0 & [133:77]==0 & [71:70]==0 & [64]==0.
  - Valid but not well-formed: drop, set fmt_err. A packet with bit144=0 is ignored regardless of its other bits.
- FIFO write:
  - Happens at the end of cycle N+1 when well-formed.
  - Stores {tid, exc, fcmp, cc, fcc, data} (76 bits).
- FIFO read:
  - First-word-fall-through. out_* are driven from the head entry.
  - out_vld = (fifo_cnt!=0).
  - A packet arriving at an empty FIFO at cycle N appears at out_vld in cycle N+2 (2-cycle latency).
- Pop:
  - Occurs when out_vld & out_rdy at the clock edge; rd_ptr increments.
  - out_rdy while out_vld=0 has no effect.
- Full:
  - Full means fifo_cnt==DEPTH.
  - A well-formed write with no simultaneous pop: drop the packet, set ovf_err, leave the FIFO unchanged.
  - Simultaneous push and pop when full: both occur, fifo_cnt stays DEPTH, no error.
- Empty: simultaneous push and pop cannot occur, since a pop needs out_vld=1.
- Pointers: wrap modulo DEPTH. fifo_cnt is +1 on push only, -1 on pop only, unchanged on both.
- Ordering: entries from different threads stay in strict arrival order.
- Errors:
  - err_clr clears both sticky flags.
  - A set event in the same cycle as err_clr wins (flag ends at 1).
- Output order: out_* are combinational from the FIFO storage read mux. No combinational path from cpx_fp_data to any output.

Optional Feature:
- FPU_CPX_RCV_AEXC_EN defined:
  - Per-thread 5-bit accrued-exception registers.
  - On each successful FIFO write, aexc[tid] |= exc.
  - aexc_clr[t] zeroes thread t. A write in the same cycle as its clear leaves aexc[t] = exc of that write.
- Undefined:
  - aexc is tied to 0 and aexc_clr is ignored; no flops are inferred.

Test Plan:
- Reset, then a packet at cycle 0: bit144=1, [143:140]=8, tid=2, exc=5'h01, data=64'h3FF0_0000_0000_0000. Required: out_vld=1 at cycle 2 with out_tid=2, out_exc=1, out_data=64'h3FF0000000000000; fifo_cnt=1.
- Compare result with [69]=1, cc=2'b10, fcc=2'b01 and out_rdy=1 held. Required: out_fcmp=1, out_cc=2, out_fcc=1; the entry pops at the next edge and fifo_cnt returns to 0.
- DEPTH=4 with out_rdy=0 and 5 back-to-back packets. Required: fifo_cnt=4 and ovf_err=1; the head is still the first packet's data.
- Full FIFO with out_rdy=1 and a new packet in the same cycle. Required: fifo_cnt stays 4, ovf_err stays 0, 5 pops return the data in order.
- Valid packet with [143:140]=4'b0100, then one with bit133 set. Required: fmt_err=1, fifo_cnt=0. Then err_clr=1 for one cycle: fmt_err=0.
- With FPU_CPX_RCV_AEXC_EN: tid1 exc=5'h02 followed by tid1 exc=5'h10. Required: aexc[9:5]=5'h12. Then aexc_clr=4'b0010: aexc[9:5]=0, other threads unchanged.
